// File: rtl/threshold_event_detector_if.sv
// Stream/control bundle between a sample producer and threshold_event_detector.
// The thr_lo_* members exist only when HYST_EN is defined.
interface threshold_event_detector_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             thr_we;
  logic [WIDTH-1:0] thr_data;
  logic             clr_cnt;
`ifdef HYST_EN
  logic             thr_lo_we;
  logic [WIDTH-1:0] thr_lo_data;
`endif
  logic             gt_q;
  logic             lt_q;
  logic             eq_q;
  logic             above;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] evt_cnt;

  modport master (
    output in_valid, in_data, thr_we, thr_data, clr_cnt,
`ifdef HYST_EN
    output thr_lo_we, thr_lo_data,
`endif
    input  gt_q, lt_q, eq_q, above, rise, fall, evt_cnt
  );

  modport slave (
    input  in_valid, in_data, thr_we, thr_data, clr_cnt,
`ifdef HYST_EN
    input  thr_lo_we, thr_lo_data,
`endif
    output gt_q, lt_q, eq_q, above, rise, fall, evt_cnt
  );
endinterface

// File: rtl/threshold_event_detector.sv
// Registers compare flags per valid sample and debounces "sample > threshold" with a
// persistence FSM, rise/fall pulses and a saturating rise counter. Optional macro: HYST_EN.
module threshold_event_detector #(
  parameter int WIDTH   = 4,
  parameter int PERSIST = 3,
  parameter int CNT_W   = 8
) (
  input logic                      clk,
  input logic                      rst,
  threshold_event_detector_if.slave bus
);

  localparam int RUN_W = $clog2(PERSIST + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(PERSIST);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    BELOW  = 2'd0,
    ARM    = 2'd1,
    ABOVE  = 2'd2,
    DISARM = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_d;
  logic [RUN_W-1:0] run_inc;
  logic [WIDTH-1:0] thr;
  logic             gt;
  logic             lt;
  logic             eq;
  logic             entry_cond;
  logic             exit_cond;
  logic             gt_r;
  logic             lt_r;
  logic             eq_r;
  logic             rise_d;
  logic             fall_d;
  logic             rise_r;
  logic             fall_r;
  logic [CNT_W-1:0] cnt_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      thr <= '0;
    end else if (bus.thr_we) begin
      thr <= bus.thr_data;
    end
  end

  assign gt         = bus.in_data > thr;
  assign lt         = bus.in_data < thr;
  assign eq         = bus.in_data == thr;
  assign entry_cond = gt;

`ifdef HYST_EN
  logic [WIDTH-1:0] thr_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      thr_lo <= '0;
    end else if (bus.thr_lo_we) begin
      thr_lo <= bus.thr_lo_data;
    end
  end

  // Strict lower threshold; thr_lo above thr is allowed and simply makes exit easier.
  assign exit_cond = bus.in_data < thr_lo;
`else
  assign exit_cond = lt | eq;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      gt_r <= 1'b0;
      lt_r <= 1'b0;
      eq_r <= 1'b0;
    end else if (bus.in_valid) begin
      gt_r <= gt;
      lt_r <= lt;
      eq_r <= eq;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BELOW;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  assign run_inc = run_q + RUN_ONE;

  // Only valid samples advance the FSM; idle cycles hold both state and run length.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (bus.in_valid) begin
      case (state_q)
        BELOW: begin
          if (entry_cond) begin
            if (PERSIST == 1) begin
              state_d = ABOVE;
              run_d   = '0;
              rise_d  = 1'b1;
            end else begin
              state_d = ARM;
              run_d   = RUN_ONE;
            end
          end
        end
        ARM: begin
          if (entry_cond) begin
            if (run_inc == RUN_MAX) begin
              state_d = ABOVE;
              run_d   = '0;
              rise_d  = 1'b1;
            end else begin
              run_d = run_inc;
            end
          end else begin
            state_d = BELOW;
            run_d   = '0;
          end
        end
        ABOVE: begin
          if (exit_cond) begin
            if (PERSIST == 1) begin
              state_d = BELOW;
              run_d   = '0;
              fall_d  = 1'b1;
            end else begin
              state_d = DISARM;
              run_d   = RUN_ONE;
            end
          end
        end
        DISARM: begin
          if (exit_cond) begin
            if (run_inc == RUN_MAX) begin
              state_d = BELOW;
              run_d   = '0;
              fall_d  = 1'b1;
            end else begin
              run_d = run_inc;
            end
          end else begin
            state_d = ABOVE;
            run_d   = '0;
          end
        end
        default: begin
          state_d = BELOW;
          run_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      rise_r <= rise_d;
      fall_r <= fall_d;
    end
  end

  // Counter updates on the same edge that raises 'rise', so both become visible together.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (bus.clr_cnt) begin
      cnt_r <= rise_d ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
    end else if (rise_d && (cnt_r != CNT_SAT)) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.gt_q    = gt_r;
  assign bus.lt_q    = lt_r;
  assign bus.eq_q    = eq_r;
  assign bus.above   = (state_q == ABOVE) || (state_q == DISARM);
  assign bus.rise    = rise_r;
  assign bus.fall    = fall_r;
  assign bus.evt_cnt = cnt_r;

endmodule

// File: tb/tb_threshold_event_detector.sv
// Self-checking bench: vector table, hand corner sequences and random traffic against a
// streak-count model; a second instance with CNT_W=2 exercises counter saturation.
module tb_threshold_event_detector;

  localparam int WIDTH   = 4;
  localparam int PERSIST = 3;

  logic clk;
  logic rst;

  threshold_event_detector_if #(.WIDTH(WIDTH), .CNT_W(8)) bus1 ();
  threshold_event_detector_if #(.WIDTH(WIDTH), .CNT_W(2)) bus2 ();

  threshold_event_detector #(.WIDTH(WIDTH), .PERSIST(PERSIST), .CNT_W(8)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  threshold_event_detector #(.WIDTH(WIDTH), .PERSIST(PERSIST), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: current level plus length of the current run of samples that would flip it.
  typedef struct packed {
    int thr;
    int thr_lo;
    int streak;
    bit level;
    bit gt;
    bit lt;
    bit eq;
    bit rise;
    bit fall;
    int cnt;
  } model_t;

  model_t m1;
  model_t m2;

  typedef struct {
    int v, d, twe, td, clr;
    int gt, lt, eq, ab, ri, fa, cnt;
  } vec_t;

  vec_t vec [29];

  function automatic model_t model_next(model_t m, bit r, bit v, int d, bit twe, int td,
                                        bit clr, bit tlw, int tld, int cnt_max);
    model_t n;
    bit     qual;
    n      = m;
    n.rise = 1'b0;
    n.fall = 1'b0;
    if (r) begin
      n = '0;
      return n;
    end
    if (v) begin
      n.gt = d > m.thr;
      n.lt = d < m.thr;
      n.eq = d == m.thr;
`ifdef HYST_EN
      qual = m.level ? (d < m.thr_lo) : (d > m.thr);
`else
      qual = m.level ? (d <= m.thr) : (d > m.thr);
`endif
      n.streak = qual ? m.streak + 1 : 0;
      if (n.streak == PERSIST) begin
        n.level  = !m.level;
        n.streak = 0;
        n.rise   = n.level;
        n.fall   = !n.level;
      end
    end
    if (clr) n.cnt = n.rise ? 1 : 0;
    else if (n.rise && n.cnt < cnt_max) n.cnt = n.cnt + 1;
    if (twe) n.thr = td;
    if (tlw) n.thr_lo = tld;
    return n;
  endfunction

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_models();
    check_output("dut1 gt_q",    int'(bus1.gt_q),    int'(m1.gt));
    check_output("dut1 lt_q",    int'(bus1.lt_q),    int'(m1.lt));
    check_output("dut1 eq_q",    int'(bus1.eq_q),    int'(m1.eq));
    check_output("dut1 above",   int'(bus1.above),   int'(m1.level));
    check_output("dut1 rise",    int'(bus1.rise),    int'(m1.rise));
    check_output("dut1 fall",    int'(bus1.fall),    int'(m1.fall));
    check_output("dut1 evt_cnt", int'(bus1.evt_cnt), m1.cnt);
    check_output("dut2 above",   int'(bus2.above),   int'(m2.level));
    check_output("dut2 rise",    int'(bus2.rise),    int'(m2.rise));
    check_output("dut2 fall",    int'(bus2.fall),    int'(m2.fall));
    check_output("dut2 evt_cnt", int'(bus2.evt_cnt), m2.cnt);
  endtask

  // One clock: drive both instances identically, advance models, sample 1ns after the edge.
  task automatic apply_stimulus(input bit r, input bit v, input int d, input bit twe,
                                input int td, input bit clr,
                                input bit tlw = 1'b0, input int tld = 0);
    logic [WIDTH-1:0] dv;
    logic [WIDTH-1:0] tv;
    logic [WIDTH-1:0] lv;
    dv = d[WIDTH-1:0];
    tv = td[WIDTH-1:0];
    lv = tld[WIDTH-1:0];
    rst           = r;
    bus1.in_valid = v;   bus2.in_valid = v;
    bus1.in_data  = dv;  bus2.in_data  = dv;
    bus1.thr_we   = twe; bus2.thr_we   = twe;
    bus1.thr_data = tv;  bus2.thr_data = tv;
    bus1.clr_cnt  = clr; bus2.clr_cnt  = clr;
`ifdef HYST_EN
    bus1.thr_lo_we   = tlw; bus2.thr_lo_we   = tlw;
    bus1.thr_lo_data = lv;  bus2.thr_lo_data = lv;
`endif
    m1 = model_next(m1, r, v, int'(dv), twe, int'(tv), clr, tlw, int'(lv), 255);
    m2 = model_next(m2, r, v, int'(dv), twe, int'(tv), clr, tlw, int'(lv), 3);
    @(posedge clk);
    #1;
    check_models();
  endtask

  initial begin
    m1 = '0;
    m2 = '0;
    vec = '{
      '{0,0,1,5,0, 0,0,0, 0,0,0, 0},
      '{1,6,0,0,0, 1,0,0, 0,0,0, 0},
      '{1,6,0,0,0, 1,0,0, 0,0,0, 0},
      '{1,6,0,0,0, 1,0,0, 1,1,0, 1},
      '{0,0,0,0,0, 1,0,0, 1,0,0, 1},
      '{1,5,0,0,0, 0,0,1, 1,0,0, 1},
      '{1,5,0,0,0, 0,0,1, 1,0,0, 1},
      '{1,5,0,0,0, 0,0,1, 0,0,1, 1},
      '{0,0,0,0,0, 0,0,1, 0,0,0, 1},
      '{1,6,0,0,0, 1,0,0, 0,0,0, 1},
      '{1,6,0,0,0, 1,0,0, 0,0,0, 1},
      '{1,4,0,0,0, 0,1,0, 0,0,0, 1},
      '{1,6,0,0,0, 1,0,0, 0,0,0, 1},
      '{1,6,0,0,0, 1,0,0, 0,0,0, 1},
      '{1,6,0,0,0, 1,0,0, 1,1,0, 2},
      '{1,4,0,0,0, 0,1,0, 1,0,0, 2},
      '{1,4,0,0,0, 0,1,0, 1,0,0, 2},
      '{1,4,0,0,0, 0,1,0, 0,0,1, 2},
      '{1,6,0,0,0, 1,0,0, 0,0,0, 2},
      '{0,0,0,0,0, 1,0,0, 0,0,0, 2},
      '{1,6,0,0,0, 1,0,0, 0,0,0, 2},
      '{0,0,0,0,0, 1,0,0, 0,0,0, 2},
      '{1,6,0,0,0, 1,0,0, 1,1,0, 3},
      '{1,3,0,0,0, 0,1,0, 1,0,0, 3},
      '{1,3,0,0,0, 0,1,0, 1,0,0, 3},
      '{1,3,0,0,0, 0,1,0, 0,0,1, 3},
      '{1,7,1,9,0, 1,0,0, 0,0,0, 3},
      '{1,7,0,0,0, 0,1,0, 0,0,0, 3},
      '{0,0,0,0,1, 0,1,0, 0,0,0, 0}
    };

    $display("[TB] reset");
    apply_stimulus(1, 0, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0);

    $display("[TB] vector table");
    foreach (vec[i]) begin
      apply_stimulus(0, vec[i].v[0], vec[i].d, vec[i].twe[0], vec[i].td, vec[i].clr[0]);
`ifndef HYST_EN
      check_output($sformatf("vec%0d gt_q", i),    int'(bus1.gt_q),    vec[i].gt);
      check_output($sformatf("vec%0d lt_q", i),    int'(bus1.lt_q),    vec[i].lt);
      check_output($sformatf("vec%0d eq_q", i),    int'(bus1.eq_q),    vec[i].eq);
      check_output($sformatf("vec%0d above", i),   int'(bus1.above),   vec[i].ab);
      check_output($sformatf("vec%0d rise", i),    int'(bus1.rise),    vec[i].ri);
      check_output($sformatf("vec%0d fall", i),    int'(bus1.fall),    vec[i].fa);
      check_output($sformatf("vec%0d evt_cnt", i), int'(bus1.evt_cnt), vec[i].cnt);
`endif
    end

    $display("[TB] reset in the middle of an arming run");
    apply_stimulus(0, 1, 10, 0, 0, 0);
    apply_stimulus(0, 1, 10, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_output("rst above", int'(bus1.above), 0);
    check_output("rst evt_cnt", int'(bus1.evt_cnt), 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1'b1, 1);
    apply_stimulus(0, 1, 10, 0, 0, 0);
    apply_stimulus(0, 1, 10, 0, 0, 0);
    check_output("post-rst no early rise", int'(bus1.rise), 0);
    check_output("post-rst still below", int'(bus1.above), 0);
    apply_stimulus(0, 1, 10, 0, 0, 0);
    check_output("post-rst rise", int'(bus1.rise), 1);
    check_output("post-rst evt_cnt", int'(bus1.evt_cnt), 1);

    $display("[TB] counter saturation");
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) apply_stimulus(0, 1, 0, 0, 0, 0);
      for (int j = 0; j < 3; j++) apply_stimulus(0, 1, 10, 0, 0, 0);
    end
    check_output("sat dut1 evt_cnt", int'(bus1.evt_cnt), 4);
    check_output("sat dut2 evt_cnt", int'(bus2.evt_cnt), 3);
    for (int j = 0; j < 3; j++) apply_stimulus(0, 1, 0, 0, 0, 0);
    apply_stimulus(0, 1, 10, 0, 0, 0);
    apply_stimulus(0, 1, 10, 0, 0, 0);
    apply_stimulus(0, 1, 10, 0, 0, 1);
    check_output("clr+rise rise", int'(bus1.rise), 1);
    check_output("clr+rise dut1 evt_cnt", int'(bus1.evt_cnt), 1);
    check_output("clr+rise dut2 evt_cnt", int'(bus2.evt_cnt), 1);

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      apply_stimulus($urandom_range(0, 199) == 0,
                     $urandom_range(0, 3) != 0,
                     int'($urandom_range(0, 15)),
                     $urandom_range(0, 19) == 0,
                     int'($urandom_range(0, 15)),
                     $urandom_range(0, 39) == 0,
                     $urandom_range(0, 19) == 0,
                     int'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
